// File: rtl/reg_file_pkg.sv
// Shared word/register-address defines plus the package view of them used by the
// register file and the operand-select mux.
`ifndef REG_FILE_DEFINES_SV
`define REG_FILE_DEFINES_SV
`define WORD_W        32
`define WORD_BUS      31:0
`define REG_ADDR_W    5
`define REG_ADDR_BUS  4:0
`define REG_NUM       32
`endif

package reg_file_pkg;

  localparam int unsigned WordW    = `WORD_W;
  localparam int unsigned RegAddrW = `REG_ADDR_W;
  localparam int unsigned RegNum   = `REG_NUM;

  typedef logic [`WORD_BUS]     word_t;
  typedef logic [`REG_ADDR_BUS] reg_addr_t;

endpackage

// File: rtl/reg_file.sv
// Two-read/one-write register file with write-back bypass and a per-register
// pending-write scoreboard for issue-time hazard detection.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = RegAddrW,
  parameter int unsigned DATA_W = WordW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] set_addr
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0]  mem_q [NumRegs];
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               wr_en, set_en;

  assign wr_en  = we && (waddr != '0);
  assign set_en = set_busy && (set_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Set is applied after clear so a newer producer issued on the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[waddr] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
        busy1  = set_busy && (set_addr == raddr1) && busy_q[raddr1];
      end else begin
        rdata1 = mem_q[raddr1];
        busy1  = busy_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
        busy2  = set_busy && (set_addr == raddr2) && busy_q[raddr2];
      end else begin
        rdata2 = mem_q[raddr2];
        busy2  = busy_q[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, r0, bypass, scoreboard,
// same-edge collision and read-enable behaviour.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re1, re2, we, set_busy;
  logic [4:0]  raddr1, raddr2, waddr, set_addr;
  logic [31:0] wdata, rdata1, rdata2;
  logic        busy1, busy2;

  int tests  = 0;
  int failed = 0;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .busy1    (busy1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .busy2    (busy2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .set_busy (set_busy),
    .set_addr (set_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    set_busy = 1'b0;
    set_addr = '0;
  endtask

  initial begin
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5;
    idle();
    #1 rst = 1'b1;
    // Writes and sets during reset are ignored and not bypassed.
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; set_busy = 1'b1; set_addr = 5'd5;
    #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_r5", rdata1, 32'h0);
    check("post_rst_busy5", 32'(busy2), 32'h0);

    // r0 ignores writes and sets.
    raddr1 = 5'd0;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; set_busy = 1'b1; set_addr = 5'd0;
    #1;
    check("r0_pre_rdata", rdata1, 32'h0);
    check("r0_pre_busy", 32'(busy1), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("r0_post_rdata", rdata1, 32'h0);
    check("r0_post_busy", 32'(busy1), 32'h0);

    // Same-cycle bypass on both ports.
    raddr1 = 5'd7; raddr2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'd102;
    #1;
    check("byp_rdata1", rdata1, 32'd102);
    check("byp_rdata2", rdata2, 32'd102);
    @(negedge clk);
    idle();
    #1;
    check("held_rdata1", rdata1, 32'd102);
    check("held_rdata2", rdata2, 32'd102);

    re2 = 1'b0;
    #1;
    check("re2_off_rdata", rdata2, 32'h0);
    check("re2_off_busy", 32'(busy2), 32'h0);
    re2 = 1'b1;

    // Scoreboard set then cleared by the write-back.
    raddr1 = 5'd9; raddr2 = 5'd9;
    set_busy = 1'b1; set_addr = 5'd9;
    #1;
    check("sb_pre_busy", 32'(busy1), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("sb_busy1", 32'(busy1), 32'h1);
    check("sb_busy2", 32'(busy2), 32'h1);
    we = 1'b1; waddr = 5'd9; wdata = 32'd78;
    #1;
    check("sb_wb_busy1", 32'(busy1), 32'h0);
    check("sb_wb_rdata1", rdata1, 32'd78);
    @(negedge clk);
    idle();
    #1;
    check("sb_done_busy", 32'(busy1), 32'h0);
    check("sb_done_rdata", rdata1, 32'd78);

    // Same-edge set and clear: set wins.
    raddr1 = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'd17; set_busy = 1'b1; set_addr = 5'd3;
    #1;
    check("col_pre_rdata", rdata1, 32'd17);
    check("col_pre_busy", 32'(busy1), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("col_rdata1", rdata1, 32'd17);
    check("col_busy1", 32'(busy1), 32'h1);

    // Write to a non-busy register leaves it non-busy.
    raddr2 = 5'd10;
    we = 1'b1; waddr = 5'd10; wdata = 32'd44;
    @(negedge clk);
    idle();
    #1;
    check("nb_rdata2", rdata2, 32'd44);
    check("nb_busy2", 32'(busy2), 32'h0);

    // Mid-cycle asynchronous reset.
    raddr1 = 5'd5; raddr2 = 5'd6;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; set_busy = 1'b1; set_addr = 5'd6;
    @(negedge clk);
    idle();
    #1;
    check("pre_arst_r5", rdata1, 32'hDEAD_BEEF);
    check("pre_arst_busy6", 32'(busy2), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("arst_rdata1", rdata1, 32'h0);
    check("arst_busy1", 32'(busy1), 32'h0);
    check("arst_busy2", 32'(busy2), 32'h0);
    we = 1'b1; waddr = 5'd5; wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rst = 1'b0;
    idle();
    raddr1 = 5'd3;
    #1;
    check("arst_r3_cleared", rdata1, 32'h0);
    check("arst_busy3_cleared", 32'(busy1), 32'h0);
    raddr1 = 5'd5;
    #1;
    check("arst_r5_cleared", rdata1, 32'h0);

    // First edge after reset performs normal writes and sets.
    we = 1'b1; waddr = 5'd5; wdata = 32'd55; set_busy = 1'b1; set_addr = 5'd6;
    @(negedge clk);
    idle();
    #1;
    check("first_edge_wr", rdata1, 32'd55);
    check("first_edge_set", 32'(busy2), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: ADDR_W, 5, register address width (32 entries).
REQ-002 Parameter: DATA_W, 32, data width; equals the shared `WORD_BUS width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: re1 / re2  input  1 each  read-port enables.
REQ-006 Port: raddr1 / raddr2  input  ADDR_W each  read addresses.
REQ-007 Port: rdata1 / rdata2  output  DATA_W each  read data to the operand-select mux.
REQ-008 Port: we  input  1  write enable (write-back stage).
REQ-009 Port: waddr  input  ADDR_W  write address.
REQ-010 Port: wdata  input  DATA_W  write data.
REQ-011 Port: set_busy  input  1  issue of an instruction that will write rd.
REQ-012 Port: set_addr  input  ADDR_W  destination register of the issuing instruction.
REQ-013 Port: busy1 / busy2  output  1 each  pending-write flag of raddr1 / raddr2.

Function
REQ-014 Storage SHALL be 2^ADDR_W words of DATA_W bits; register 0 SHALL always read 0 and ignore writes.
REQ-015 Write SHALL occur on rising clk when we=1 and waddr!=0; one-cycle latency to storage.
REQ-016 Read SHALL be combinational: rdata = 0 if re=0 or raddr=0; else wdata if we=1 and waddr==raddr (same-cycle bypass); else stored word.
REQ-017 Both read ports SHALL operate independently and may address the same register in the same cycle.
REQ-018 Scoreboard: one busy bit per register; bit 0 SHALL be constant 0.
REQ-019 On rising clk, set_busy=1 and set_addr!=0 SHALL set busy[set_addr].
REQ-020 On rising clk, we=1 and waddr!=0 SHALL clear busy[waddr].
REQ-021 Same-edge set and clear of the same register SHALL leave the bit set (newer producer wins).
REQ-022 busyN SHALL be 0 when reN=0 or raddrN=0; 0 when we=1 and waddr==raddrN with no same-cycle set_busy to that address (bypass satisfies the read); else busy[raddrN].
REQ-023 Writes to a non-busy register SHALL be legal and SHALL leave its busy bit 0.
REQ-024 No X SHALL propagate to outputs for any address value.

Reset
REQ-025 rst=1 SHALL clear all storage words and all busy bits immediately, without waiting for clk.
REQ-026 While rst=1, rdata1/rdata2 SHALL be 0 and busy1/busy2 SHALL be 0; bypass SHALL be suppressed.
REQ-027 we and set_busy asserted during rst SHALL be ignored; reset mid-sequence discards all pending state.
REQ-028 The first edge after rst deassertion SHALL perform normal writes and sets.

Structure
REQ-029 Word width, register-address width and register count SHALL come from the shared defines header (`WORD_BUS, register-address bus macro) also used by the operand mux.
REQ-030 A single module; the scoreboard SHALL be one always block in the same file (no sub-module), total 120-400 lines RTL.

Verification
REQ-031 Reset: write 0xDEADBEEF to r5, assert rst mid-cycle -> rdata1 (raddr1=5) = 0 before the next edge; busy1=0.
REQ-032 r0: we=1, waddr=0, wdata=0xFFFFFFFF; set_busy with set_addr=0 -> rdata1(raddr1=0)=0, busy1=0.
REQ-033 Bypass: we=1, waddr=7, wdata=102, raddr1=raddr2=7 in same cycle -> rdata1=rdata2=102 before the edge; 102 held after we drops.
REQ-034 Scoreboard: set_busy r9 edge -> busy1(raddr1=9)=1; next cycle we r9=78 -> busy1=0 combinationally, rdata1=78.
REQ-035 Collision: same edge set_busy r3 and we r3=17 -> after edge rdata1=17, busy1=1.
REQ-036 Read enable: re2=0 with raddr2=7 holding 102 -> rdata2=0, busy2=0.
